interval_tick_scheduler: RTL and testbench



---
 rtl/interval_tick_scheduler.sv | 124 ++++++++++++
 tb/tb_interval_tick_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_tick_scheduler.sv
// Shares one down-counting interval timer among NREQ requesters.
// Round-robin arbitration, per-requester period, one-cycle DONE pulse on completion.
module interval_tick_scheduler #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] PERIOD,
    output logic [NREQ-1:0]       GRANT,
    output logic [NREQ-1:0]       DONE,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      COUNT_OUT
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t            state, state_next;
    logic [IW-1:0]     ptr, ptr_next;
    logic [IW-1:0]     owner, owner_next, owner_inc;
    logic [IW-1:0]     pick;
    logic              found;
    int unsigned       idx;
    logic [WIDTH-1:0]  sel_period;
    logic [WIDTH-1:0]  count_next;
    logic [NREQ-1:0]   grant_next, done_next;
    logic              busy_next;

    // First set request searching upward from the pointer, wrapping around
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        idx        = 0;
        sel_period = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && REQ[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                sel_period = PERIOD[i*WIDTH +: WIDTH];
            end
        end
    end

    assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : IW'(owner + IW'(1));

    // Next-state and next-output logic
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        count_next = COUNT_OUT;
        grant_next = GRANT;
        done_next  = '0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_next = S_COUNT;
                    owner_next = pick;
                    grant_next = NREQ'(1) << pick;
                    count_next = (sel_period == '0) ? WIDTH'(1) : sel_period;
                end
            end
            S_COUNT: begin
                // A dropped request wins over completion on the same edge
                if (!REQ[owner]) begin
                    state_next = S_IDLE;
                    grant_next = '0;
                    count_next = '0;
                    ptr_next   = owner_inc;
                end else if (COUNT_OUT == WIDTH'(1)) begin
                    state_next = S_DONE;
                    grant_next = '0;
                    count_next = '0;
                    done_next  = NREQ'(1) << owner;
                end else begin
                    count_next = COUNT_OUT - WIDTH'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                ptr_next   = owner_inc;
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
                count_next = '0;
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            GRANT     <= '0;
            DONE      <= '0;
            BUSY      <= 1'b0;
            COUNT_OUT <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            owner     <= owner_next;
            GRANT     <= grant_next;
            DONE      <= done_next;
            BUSY      <= busy_next;
            COUNT_OUT <= count_next;
        end
    end

    a_grant_onehot: assert property (@(posedge CLOCK) disable iff (RESET) $onehot0(GRANT));
    a_done_onehot:  assert property (@(posedge CLOCK) disable iff (RESET) $onehot0(DONE));
    a_exclusive:    assert property (@(posedge CLOCK) disable iff (RESET) !((|GRANT) && (|DONE)));

endmodule

// File: tb/tb_interval_tick_scheduler.sv
// Scoreboard bench for interval_tick_scheduler: directed stimulus pushes expected
// grant/done/abort events, a negedge monitor pops and compares them.
module tb_interval_tick_scheduler;

    localparam int unsigned W  = 20;
    localparam int unsigned N  = 4;
    localparam int unsigned WS = 4;

    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   period = '0;
    logic [N-1:0]     grant, done;
    logic             busy;
    logic [W-1:0]     count_out;

    logic [N-1:0]     req_s = '0;
    logic [N*WS-1:0]  period_s = '0;
    logic [N-1:0]     grant_s, done_s;
    logic             busy_s;
    logic [WS-1:0]    count_s;

    always #5 clock = ~clock;

    interval_tick_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .CLOCK(clock), .RESET(reset), .REQ(req), .PERIOD(period),
        .GRANT(grant), .DONE(done), .BUSY(busy), .COUNT_OUT(count_out)
    );

    interval_tick_scheduler #(.WIDTH(WS), .NREQ(N)) dut_s (
        .CLOCK(clock), .RESET(reset), .REQ(req_s), .PERIOD(period_s),
        .GRANT(grant_s), .DONE(done_s), .BUSY(busy_s), .COUNT_OUT(count_s)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int           kind;
        logic [N-1:0] val;
        int           n;
    } ev_t;

    ev_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [N-1:0] val, input int n);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.n    = n;
        sb.push_back(e);
    endtask

    task automatic sb_match(input int kind, input logic [N-1:0] val, input int n);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%b n=%0d with empty queue", kind, val, n);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val !== val || (e.n >= 0 && e.n != n)) begin
                bad++;
                $display("FAIL event: got kind=%0d val=%b n=%0d expected kind=%0d val=%b n=%0d",
                         kind, val, n, e.kind, e.val, e.n);
            end
        end
    endtask

    // Monitor: grant rise (with idle gap), done (with grant length), abort (fall without done)
    logic [N-1:0] prev_g = '0;
    int glen = 0;
    int gap  = -1;

    always @(negedge clock) begin
        if (reset) begin
            prev_g = '0;
            glen   = 0;
            gap    = -1;
        end else begin
            if (grant != 0 && prev_g == 0) begin
                glen = 0;
                sb_match(K_GRANT, grant, gap);
            end
            if (grant != 0) glen++;
            if (done != 0) sb_match(K_DONE, done, glen);
            else if (grant == 0 && prev_g != 0) sb_match(K_ABORT, prev_g, glen);
            if (grant == 0) gap = (prev_g != 0) ? 1 : ((gap >= 0) ? gap + 1 : -1);
            prev_g = grant;
        end
    end

    task automatic wait_grant();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (grant != 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 32'(grant), 32'hFFFF_FFFF);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (done != 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'(done), 32'hFFFF_FFFF);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_c[7] = '{5, 4, 3, 2, 1, 0, 0};
        int exp_b[7] = '{1, 1, 1, 1, 1, 1, 0};
        int n;
        bit got;

        // Reset values
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count_out), 0);

        // Single requester, period 5
        push(K_GRANT, 4'b0001, -1);
        push(K_DONE, 4'b0001, 5);
        period[0*W +: W] = 20'd5;
        req = 4'b0001;
        wait_grant();
        for (int i = 0; i < 7; i++) begin
            chk("single_count", 32'(count_out), 32'(exp_c[i]));
            chk("single_busy", 32'(busy), 32'(exp_b[i]));
            if (i == 5) req = '0;
            if (i < 6) @(negedge clock);
        end

        // Round-robin fairness from pointer 0
        do_reset();
        for (int i = 0; i < 4; i++) period[i*W +: W] = 20'd3;
        push(K_GRANT, 4'b0001, -1); push(K_DONE, 4'b0001, 3);
        push(K_GRANT, 4'b0010, 2);  push(K_DONE, 4'b0010, 3);
        push(K_GRANT, 4'b0100, 2);  push(K_DONE, 4'b0100, 3);
        push(K_GRANT, 4'b1000, 2);  push(K_DONE, 4'b1000, 3);
        push(K_GRANT, 4'b0001, 2);  push(K_DONE, 4'b0001, 3);
        @(negedge clock);
        req = 4'b1111;
        repeat (5) wait_done();
        req = '0;

        // Zero period loads as 1
        push(K_GRANT, 4'b0010, -1);
        push(K_DONE, 4'b0010, 1);
        period[1*W +: W] = '0;
        req = 4'b0010;
        wait_done();
        req = '0;

        // Abort after 4 grant cycles, pointer moves to 3
        push(K_GRANT, 4'b0100, -1);
        push(K_ABORT, 4'b0100, 4);
        period[2*W +: W] = 20'd10;
        req = 4'b0100;
        wait_grant();
        repeat (3) @(negedge clock);
        req = '0;
        @(negedge clock);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_count", 32'(count_out), 0);
        push(K_GRANT, 4'b1000, -1);
        push(K_DONE, 4'b1000, 3);
        req = 4'b1001;
        wait_done();
        req = '0;

        // Async reset mid-count at COUNT_OUT=7
        push(K_GRANT, 4'b0010, -1);
        period[1*W +: W] = 20'd10;
        req = 4'b0010;
        wait_grant();
        repeat (3) @(negedge clock);
        chk("pre_reset_count", 32'(count_out), 7);
        #2 reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 0);
        chk("async_done", 32'(done), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_count", 32'(count_out), 0);
        push(K_GRANT, 4'b0010, -1);
        push(K_DONE, 4'b0010, 10);
        @(negedge clock);
        #2 reset = 1'b0;
        wait_done();
        req = '0;

        // Period change during count has no effect
        push(K_GRANT, 4'b0001, -1);
        push(K_DONE, 4'b0001, 6);
        period[0*W +: W] = 20'd6;
        req = 4'b0001;
        wait_grant();
        repeat (2) @(negedge clock);
        period[0*W +: W] = 20'd2;
        wait_done();
        req = '0;

        // Full-scale period loads unmodified and decrements
        push(K_GRANT, 4'b0001, -1);
        push(K_ABORT, 4'b0001, 2);
        period[0*W +: W] = 20'hFFFFF;
        req = 4'b0001;
        wait_grant();
        chk("max_load", 32'(count_out), 32'h000F_FFFF);
        @(negedge clock);
        chk("max_dec", 32'(count_out), 32'h000F_FFFE);
        req = '0;
        @(negedge clock);
        chk("max_abort_busy", 32'(busy), 0);

        // Reduced-width build: full-scale period 15
        period_s[0 +: WS] = 4'hF;
        req_s = 4'b0001;
        n   = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (grant_s != 0) begin
                if (n == 0) chk("small_load", 32'(count_s), 15);
                n++;
            end
            if (done_s != 0) begin
                got = 1;
                break;
            end
        end
        chk("small_len", 32'(n), 15);
        chk("small_done", got ? 32'(done_s) : 32'h0, 1);
        req_s = '0;

        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
